fp_round_unit: RTL
==================

FP_ROUND_UNIT -- requirements
Module: fp_round_unit

Interface
REQ-001 CLK  in  1  rising-edge clock; all state changes on CLK rising edge.
REQ-002 Reset  in  1  reset Reset, synchronous, active-high; clock CLK.
REQ-003 StartR  in  1  round request (level) from multiplier controller.
REQ-004 Sign_i  in  1  product sign, sampled at capture.
REQ-005 Exp_i  in  10  biased product exponent (Ea+Eb-127), two's complement, sampled at capture.
REQ-006 Mant_i  in  48  raw 24x24 significand product (hidden bits included), sampled at capture.
REQ-007 DoneR  out  1  result valid / request acknowledged.
REQ-008 Over2  out  1  exponent overflow after rounding; result forced to infinity.
REQ-009 Under  out  1  exponent underflow (final exponent <= 0); result flushed to signed zero.
REQ-010 Result_o  out  32  IEEE-754 single result {sign, exp[7:0], frac[22:0]}.

Function
REQ-011 FSM states IDLE, NORM, ROUND, RENORM, CHECK, DONE; one cycle each except IDLE/DONE.
REQ-012 IDLE: StartR=1 sampled -> capture Sign_i/Exp_i/Mant_i, clear Over2/Under/Result_o, go NORM; else stay.
REQ-013 NORM: if M[47]=1 -> sig=M[47:24], guard=M[23], sticky=|M[22:0], exp=exp+1; else sig=M[46:23], guard=M[22], sticky=|M[21:0]; go ROUND.
REQ-014 ROUND: round-to-nearest-even; increment when guard & (sticky | sig[0]); 25-bit sum; go RENORM.
REQ-015 RENORM: if sum[24]=1 -> sig=sum[24:1], exp=exp+1; go CHECK.
REQ-016 Exponent held internally in 11-bit signed; no wrap on the two possible increments.
REQ-017 CHECK: exp>=255 -> Over2=1, Result_o={sign,8'hFF,23'h0}; exp<=0 -> Under=1, Result_o={sign,31'h0}; else Result_o={sign,exp[7:0],sig[22:0]}; go DONE.
REQ-018 DONE: DoneR=1; stay while StartR=1; StartR=0 -> IDLE, DoneR=0 from that edge.
REQ-019 Latency: DoneR high after the 5th rising edge counting the capture edge as 1st.
REQ-020 Result_o/Over2/Under stable from DoneR rise until next capture.
REQ-021 StartR held high through DONE never retriggers; new op requires StartR low for >=1 sampled cycle.
REQ-022 StartR dropped mid-operation (NORM..CHECK) ignored; operation completes; DONE exits on next edge if StartR still low.
REQ-023 Over2 and Under mutually exclusive.

Reset
REQ-024 Reset=1 at edge: state IDLE, DoneR=0, Over2=0, Under=0, Result_o=0, internal regs 0.
REQ-025 Reset mid-operation aborts; no DoneR pulse for aborted op; Reset has priority over StartR.

Structure
REQ-026 Shared package fp_mul_pkg: state encoding, BIAS=127, EXP_MAX=255, MANT_W=24, PROD_W=48.
REQ-027 One combinational sub-module fp_rne_decide (sig lsb, guard, sticky -> round-up bit); rest in fp_round_unit.

Verification
REQ-028 Exp_i=127, Mant_i=48'h900000000000, Sign_i=0 (1.5*1.5) -> Result_o=32'h40100000, Over2=0, Under=0, DoneR at edge 5.
REQ-029 Exp_i=127, Mant_i=48'h7FFFFFC00000 (tie, lsb=1, carry-out) -> Result_o=32'h40000000.
REQ-030 Exp_i=127, Mant_i=48'h400000400000 (tie, lsb=0) -> Result_o=32'h3F800000, no increment.
REQ-031 Exp_i=254, Mant_i=48'h900000000000 -> Over2=1, Result_o=32'h7F800000; Exp_i=0, Mant_i=48'h400000000000, Sign_i=1 -> Under=1, Result_o=32'h80000000.
REQ-032 StartR held high 20 cycles -> single op, DoneR high until StartR low, then DoneR=0 next edge; second StartR pulse -> second result.
REQ-033 Reset asserted in ROUND -> next edge IDLE, all outputs 0, no DoneR; following StartR completes normally.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier datapath: field widths, exponent limits, FSM encoding
// and a result-packing helper.
package fp_mul_pkg;

  localparam int unsigned BIAS     = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned EXP_IN_W = 10;
  localparam int unsigned EXP_W    = 11;

  localparam logic signed [EXP_W-1:0] EXP_OVF  = 11'sd255;
  localparam logic signed [EXP_W-1:0] EXP_ZERO = 11'sd0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StNorm   = 3'd1,
    StRound  = 3'd2,
    StRenorm = 3'd3,
    StCheck  = 3'd4,
    StDone   = 3'd5
  } state_t;

  function automatic logic [31:0] pack_result(input logic sign, input logic [7:0] exp,
                                              input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_rne_decide.sv
// Round-to-nearest-even decision: round up above half, or at exactly half when the lsb is odd.
module fp_rne_decide (
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic round_up
);

  always_comb begin
    round_up = guard & (sticky | lsb);
  end

endmodule

// File: rtl/fp_round_unit.sv
// Normalise, round (RNE) and pack a raw 24x24 significand product into an IEEE-754 single,
// flagging exponent overflow (forced infinity) and underflow (flushed to signed zero).
module fp_round_unit
  import fp_mul_pkg::*;
(
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  StartR,
  input  logic                  Sign_i,
  input  logic [EXP_IN_W-1:0]   Exp_i,
  input  logic [PROD_W-1:0]     Mant_i,
  output logic                  DoneR,
  output logic                  Over2,
  output logic                  Under,
  output logic [31:0]           Result_o
);

  state_t                   state;
  logic                     sign;
  logic signed [EXP_W-1:0]  exp;
  logic [PROD_W-1:0]        mant;
  logic [MANT_W-1:0]        sig;
  logic                     guard;
  logic                     sticky;
  logic [MANT_W:0]          sum;
  logic                     round_up;

  fp_rne_decide u_rne (
    .lsb      (sig[0]),
    .guard    (guard),
    .sticky   (sticky),
    .round_up (round_up)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= StIdle;
      sign     <= 1'b0;
      exp      <= '0;
      mant     <= '0;
      sig      <= '0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      sum      <= '0;
      DoneR    <= 1'b0;
      Over2    <= 1'b0;
      Under    <= 1'b0;
      Result_o <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (StartR) begin
            sign     <= Sign_i;
            exp      <= {Exp_i[EXP_IN_W-1], Exp_i};
            mant     <= Mant_i;
            Over2    <= 1'b0;
            Under    <= 1'b0;
            Result_o <= '0;
            state    <= StNorm;
          end
        end
        StNorm: begin
          // Product of two [1,2) significands lies in [1,4): at most one bit of left slack.
          if (mant[PROD_W-1]) begin
            sig    <= mant[PROD_W-1 -: MANT_W];
            guard  <= mant[PROD_W-MANT_W-1];
            sticky <= |mant[PROD_W-MANT_W-2:0];
            exp    <= exp + 11'sd1;
          end else begin
            sig    <= mant[PROD_W-2 -: MANT_W];
            guard  <= mant[PROD_W-MANT_W-2];
            sticky <= |mant[PROD_W-MANT_W-3:0];
          end
          state <= StRound;
        end
        StRound: begin
          sum   <= {1'b0, sig} + {{MANT_W{1'b0}}, round_up};
          state <= StRenorm;
        end
        StRenorm: begin
          // A carry out means the significand rounded up to exactly 2.0.
          if (sum[MANT_W]) begin
            sig <= sum[MANT_W:1];
            exp <= exp + 11'sd1;
          end else begin
            sig <= sum[MANT_W-1:0];
          end
          state <= StCheck;
        end
        StCheck: begin
          if (exp >= EXP_OVF) begin
            Over2    <= 1'b1;
            Result_o <= pack_result(sign, 8'hFF, 23'h0);
          end else if (exp <= EXP_ZERO) begin
            Under    <= 1'b1;
            Result_o <= pack_result(sign, 8'h00, 23'h0);
          end else begin
            Result_o <= pack_result(sign, exp[7:0], sig[22:0]);
          end
          DoneR <= 1'b1;
          state <= StDone;
        end
        StDone: begin
          if (!StartR) begin
            DoneR <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
